// File: rtl/lock_piece.sv
// Commits a landed tetromino into board RAM: expands the piece via lut, bounds- and
// collision-checks the four cells, then writes the colour only if every check passes.

module lut (
  input  logic [2:0] block,
  input  logic [1:0] rotation,
  output logic [7:0] coord_x,
  output logic [7:0] coord_y,
  output logic [5:0] colour
);
  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [1:0] span;

  always_comb begin
    base_x = {2'd1, 2'd0, 2'd1, 2'd0};
    base_y = {2'd1, 2'd1, 2'd0, 2'd0};
    span   = 2'd1;
    colour = 6'h3C;
    case (block)
      3'd0: begin base_x = {2'd3, 2'd2, 2'd1, 2'd0}; base_y = {2'd1, 2'd1, 2'd1, 2'd1}; span = 2'd3; colour = 6'h1B; end
      3'd2: begin base_x = {2'd2, 2'd1, 2'd0, 2'd1}; base_y = {2'd1, 2'd1, 2'd1, 2'd0}; span = 2'd2; colour = 6'h22; end
      3'd3: begin base_x = {2'd1, 2'd0, 2'd2, 2'd1}; base_y = {2'd1, 2'd1, 2'd0, 2'd0}; span = 2'd2; colour = 6'h0C; end
      3'd4: begin base_x = {2'd2, 2'd1, 2'd1, 2'd0}; base_y = {2'd1, 2'd1, 2'd0, 2'd0}; span = 2'd2; colour = 6'h30; end
      3'd5: begin base_x = {2'd2, 2'd1, 2'd0, 2'd0}; base_y = {2'd1, 2'd1, 2'd1, 2'd0}; span = 2'd2; colour = 6'h03; end
      3'd6: begin base_x = {2'd2, 2'd1, 2'd0, 2'd2}; base_y = {2'd1, 2'd1, 2'd1, 2'd0}; span = 2'd2; colour = 6'h34; end
      default: ;
    endcase
  end

  // Clockwise quarter turns inside the piece's bounding box (side = span + 1)
  always_comb begin
    coord_x = '0;
    coord_y = '0;
    for (int k = 0; k < 4; k++) begin
      case (rotation)
        2'd0: begin coord_x[2*k +: 2] = base_x[2*k +: 2];        coord_y[2*k +: 2] = base_y[2*k +: 2];        end
        2'd1: begin coord_x[2*k +: 2] = span - base_y[2*k +: 2]; coord_y[2*k +: 2] = base_x[2*k +: 2];        end
        2'd2: begin coord_x[2*k +: 2] = span - base_x[2*k +: 2]; coord_y[2*k +: 2] = span - base_y[2*k +: 2]; end
        default: begin coord_x[2*k +: 2] = base_y[2*k +: 2];     coord_y[2*k +: 2] = span - base_x[2*k +: 2]; end
      endcase
    end
  end
endmodule

module lock_piece #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] block,
  input  logic [1:0] rotation,
  input  logic [3:0] anchor_x,
  input  logic [4:0] anchor_y,
  input  logic [5:0] ram_Q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic       collision
);
  typedef enum logic [2:0] {IDLE, BOUND, READ, TAIL, WRITE, DONE} state_t;

  state_t     state_reg;
  logic [1:0] idx_reg;
  logic [2:0] block_reg;
  logic [1:0] rotation_reg;
  logic [3:0] anchor_x_reg;
  logic [4:0] anchor_y_reg;
  logic [5:0] colour_reg;
  logic       occupied_reg;
  logic [7:0] ram_addr_reg;
  logic       ram_wren_reg;
  logic       done_reg;
  logic       collision_reg;

  logic [2:0] lut_block;
  logic [1:0] lut_rotation;
  logic [7:0] coord_x;
  logic [7:0] coord_y;
  logic [5:0] lut_colour;

  // In IDLE the lut sees the live inputs so the colour can be latched with start
  assign lut_block    = (state_reg == IDLE) ? block    : block_reg;
  assign lut_rotation = (state_reg == IDLE) ? rotation : rotation_reg;

  lut u_lut (
    .block    (lut_block),
    .rotation (lut_rotation),
    .coord_x  (coord_x),
    .coord_y  (coord_y),
    .colour   (lut_colour)
  );

  logic [4:0] cx [4];
  logic [5:0] cy [4];
  logic [7:0] addr [4];
  logic [3:0] oob_cell;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    assign cx[gi]       = {1'b0, anchor_x_reg} + {3'b0, coord_x[2*gi +: 2]};
    assign cy[gi]       = {1'b0, anchor_y_reg} + {4'b0, coord_y[2*gi +: 2]};
    assign addr[gi]     = {2'b0, cy[gi]} * 8'(BOARD_W) + {3'b0, cx[gi]};
    assign oob_cell[gi] = (cx[gi] > 5'(BOARD_W - 1)) || (cy[gi] > 6'(BOARD_H - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      block_reg     <= 3'd0;
      rotation_reg  <= 2'd0;
      anchor_x_reg  <= 4'd0;
      anchor_y_reg  <= 5'd0;
      colour_reg    <= 6'd0;
      occupied_reg  <= 1'b0;
      ram_addr_reg  <= 8'd0;
      ram_wren_reg  <= 1'b0;
      done_reg      <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            block_reg    <= block;
            rotation_reg <= rotation;
            anchor_x_reg <= anchor_x;
            anchor_y_reg <= anchor_y;
            colour_reg   <= lut_colour;
            occupied_reg <= 1'b0;
            state_reg    <= BOUND;
          end
        end
        BOUND: begin
          if (|oob_cell) begin
            collision_reg <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg      <= 2'd0;
            ram_addr_reg <= addr[0];
            state_reg    <= READ;
          end
        end
        READ: begin
          // ram_Q lags the address by one cycle, so it belongs to cell idx-1
          if (idx_reg != 2'd0)
            occupied_reg <= occupied_reg | (ram_Q != 6'd0);
          if (idx_reg == 2'd3) begin
            state_reg <= TAIL;
          end else begin
            idx_reg      <= idx_reg + 2'd1;
            ram_addr_reg <= addr[idx_reg + 2'd1];
          end
        end
        TAIL: begin
          if (occupied_reg || (ram_Q != 6'd0)) begin
            collision_reg <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg      <= 2'd0;
            ram_addr_reg <= addr[0];
            ram_wren_reg <= 1'b1;
            state_reg    <= WRITE;
          end
        end
        WRITE: begin
          if (idx_reg == 2'd3) begin
            ram_wren_reg  <= 1'b0;
            collision_reg <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg      <= idx_reg + 2'd1;
            ram_addr_reg <= addr[idx_reg + 2'd1];
          end
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_reg;
  assign ram_data  = colour_reg;
  assign ram_wren  = ram_wren_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign collision = collision_reg;
endmodule

// File: tb/tb_lock_piece.sv
// Randomised and directed bench for lock_piece against a cell-list board model
// with a registered-read board RAM.

module tb_lock_piece;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] block;
  logic [1:0] rotation;
  logic [3:0] anchor_x;
  logic [4:0] anchor_y;
  logic [5:0] ram_Q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic       collision;

  always #5 clk = ~clk;

  lock_piece #(.BOARD_W(10), .BOARD_H(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .block     (block),
    .rotation  (rotation),
    .anchor_x  (anchor_x),
    .anchor_y  (anchor_y),
    .ram_Q     (ram_Q),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  // Board RAM with one-cycle registered read; the bench preloads through pre_*
  logic [5:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [5:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_data;
    ram_Q <= mem[ram_addr];
  end

  // Reference shapes: rotation-0 cell offsets, bounding box side, colour
  int shape_x [8][4] = '{'{0,1,2,3}, '{0,1,0,1}, '{1,0,1,2}, '{1,2,0,1},
                         '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}, '{0,1,0,1}};
  int shape_y [8][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1},
                         '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}, '{0,0,1,1}};
  int box_side [8]   = '{4, 2, 3, 3, 3, 3, 3, 2};
  int colour_tab [8] = '{'h1B, 'h3C, 'h22, 'h0C, 'h30, 'h03, 'h34, 'h3C};

  int model [256];
  int exp_addr [4];
  bit exp_oob;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expand(input int b, input int r, input int ax, input int ay);
    int x, y, t, cx, cy;
    exp_oob = 1'b0;
    for (int k = 0; k < 4; k++) begin
      x = shape_x[b][k];
      y = shape_y[b][k];
      for (int i = 0; i < r; i++) begin
        t = x;
        x = box_side[b] - 1 - y;
        y = t;
      end
      cx = ax + x;
      cy = ay + y;
      if (cx > 9 || cy > 23) exp_oob = 1'b1;
      exp_addr[k] = (cy * 10 + cx) % 256;
    end
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 8'(a);
    pre_data = 6'(d);
    @(negedge clk);
    pre_we   = 1'b0;
    model[a] = d;
  endtask

  task automatic check_board(input string tag);
    int bad = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++)
      if (int'(mem[i]) != model[i]) bad++;
    check_val(tag, bad, 0);
  endtask

  // One commit attempt; inject = cycle index to raise start again, rst_at = cycle to pulse reset
  task automatic run_op(input int b, input int r, input int ax, input int ay,
                        input int inject, input int rst_at, input bit addr_zero);
    int done_at = -1;
    int done_cnt = 0;
    int coll = -1;
    int busy_err = 0;
    int addr_err = 0;
    int wr_n = 0;
    int wr_err = 0;
    int rd_err = 0;
    int rd [4];
    int colr, exp_done, exp_coll;
    bit occ = 1'b0;

    expand(b, r, ax, ay);
    colr = colour_tab[b];
    if (!exp_oob)
      for (int k = 0; k < 4; k++)
        if (model[exp_addr[k]] != 0) occ = 1'b1;
    exp_done = exp_oob ? 1 : (occ ? 6 : 10);
    exp_coll = (exp_oob || occ) ? 1 : 0;

    @(negedge clk);
    block    = 3'(b);
    rotation = 2'(r);
    anchor_x = 4'(ax);
    anchor_y = 5'(ay);
    start    = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (c == 0) begin
        block    = 3'($urandom);
        rotation = 2'($urandom);
        anchor_x = 4'($urandom);
        anchor_y = 5'($urandom);
      end
      if (rst_at >= 0 && c == rst_at) begin
        #2 reset = 1'b0;
        #1;
        check_val("rst_wren", int'(ram_wren), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_collision", int'(collision), 0);
        for (int k = 0; k < 4; k++)
          if (6 + k < rst_at) model[exp_addr[k]] = colr;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_board("rst_board");
        $display("op blk=%0d rot=%0d anchor=(%0d,%0d) reset at cycle %0d", b, r, ax, ay, rst_at);
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          coll    = int'(collision);
        end
      end
      if (busy !== (c <= exp_done)) busy_err++;
      if (ram_wren) begin
        if (wr_n >= 4 || c != 6 + wr_n || int'(ram_addr) != exp_addr[wr_n] || int'(ram_data) != colr)
          wr_err++;
        wr_n++;
      end
      if (c >= 1 && c <= 4) rd[c-1] = int'(ram_addr);
      if (addr_zero && ram_addr != 8'd0) addr_err++;
      start = (c == inject);
    end
    start = 1'b0;

    if (exp_coll == 0)
      for (int k = 0; k < 4; k++) model[exp_addr[k]] = colr;

    check_val("done_cycle", done_at, exp_done);
    check_val("done_count", done_cnt, 1);
    check_val("collision", coll, exp_coll);
    check_val("write_count", wr_n, exp_coll ? 0 : 4);
    check_val("write_content", wr_err, 0);
    check_val("busy_profile", busy_err, 0);
    if (!exp_oob) begin
      for (int k = 0; k < 4; k++)
        if (rd[k] != exp_addr[k]) rd_err++;
      check_val("read_addr", rd_err, 0);
    end
    if (addr_zero) check_val("addr_idle_zero", addr_err, 0);
    check_board("board");
    $display("op blk=%0d rot=%0d anchor=(%0d,%0d) done@%0d collision=%0d writes=%0d",
             b, r, ax, ay, done_at, coll, wr_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    block    = 3'd0;
    rotation = 2'd0;
    anchor_x = 4'd0;
    anchor_y = 5'd0;
    pre_we   = 1'b0;
    pre_addr = 8'd0;
    pre_data = 6'd0;
    for (int i = 0; i < 256; i++) poke(i, 0);

    check_val("reset_ram_addr", int'(ram_addr), 0);
    check_val("reset_ram_data", int'(ram_data), 0);
    check_val("reset_ram_wren", int'(ram_wren), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_collision", int'(collision), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_busy", int'(busy), 0);

    // Horizontal I past the right edge, straight after reset
    run_op(0, 0, 8, 5, -1, -1, 1'b1);
    // O at (4,10) on an empty board
    run_op(1, 0, 4, 10, -1, -1, 1'b0);
    check_val("o_cell_104", model[104], 'h3C);
    check_val("o_cell_115", model[115], 'h3C);
    poke(104, 0); poke(105, 0); poke(114, 0); poke(115, 0);
    // Same O with one target cell already taken
    poke(115, 'h21);
    run_op(1, 0, 4, 10, -1, -1, 1'b0);
    poke(115, 0);
    // Bottom row overflow
    run_op(2, 0, 0, 23, -1, -1, 1'b0);
    // Vertical I reaching row 23
    run_op(0, 1, 6, 20, -1, -1, 1'b0);
    // Restart during READ and during DONE are both ignored
    run_op(1, 0, 0, 4, 2, -1, 1'b0);
    run_op(2, 2, 3, 12, 10, -1, 1'b0);
    // Reset in the second write cycle, then a clean commit elsewhere
    run_op(5, 1, 2, 6, -1, 7, 1'b0);
    run_op(3, 0, 6, 14, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 6; j++)
        poke($urandom_range(0, 239), ($urandom_range(0, 9) < 3) ? $urandom_range(1, 63) : 0);
      run_op($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 10),
             $urandom_range(0, 23), -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
